// File: rtl/instruction_decoder_pkg.sv
// Shared definitions for the two-byte fetch instruction decoder: widths,
// opcode constants, FSM state encoding and instruction-register field positions.
package instruction_decoder_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IR_W   = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 6;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned RD_LSB     = 9;
  localparam int unsigned RS_MSB     = 8;
  localparam int unsigned RS_LSB     = 6;
  localparam int unsigned IMM_MSB    = 5;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
  localparam logic [OP_W-1:0] OP_SUBI = 4'h9;
  localparam logic [OP_W-1:0] OP_LDI  = 4'hA;
  localparam logic [OP_W-1:0] OP_BRO  = 4'hB;
  localparam logic [OP_W-1:0] OP_ANDI = 4'hC;
  localparam logic [OP_W-1:0] OP_ORI  = 4'hD;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    VALID    = 2'd2,
    HALTED   = 2'd3
  } state_t;

endpackage

// File: rtl/instruction_decoder_program_counter.sv
// 8-bit fetch program counter: load has priority over increment, wraps silently.
module instruction_decoder_program_counter
  import instruction_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// Fetches 16-bit instructions as two bytes (high first), presents decoded
// fields until accepted, supports branch redirect and a terminal halt state.
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [BYTE_W-1:0] mem_data,
  input  logic              mem_ready,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              decode_valid,
  input  logic              decode_accept,
  output logic [OP_W-1:0]   opcode,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs,
  output logic [IMM_W-1:0]  immediate_data,
  output logic              cs,
  output logic              halt
);

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q;
  logic              pc_inc, pc_load, load_hi, load_lo;
  logic              fetch_done;

  // A byte only counts while a request is actually outstanding.
  assign fetch_done = mem_read & mem_ready;

  instruction_decoder_program_counter u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (pc_inc),
    .load       (pc_load),
    .load_value (branch_target),
    .pc         (mem_addr)
  );

  // Next-state logic; branch outranks both memory and consumer handshakes.
  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    load_hi = 1'b0;
    load_lo = 1'b0;
    case (state_q)
      FETCH_HI: begin
        if (branch) begin
          pc_load = 1'b1;
          state_d = FETCH_HI;
        end else if (fetch_done) begin
          load_hi = 1'b1;
          pc_inc  = 1'b1;
          state_d = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (branch) begin
          pc_load = 1'b1;
          state_d = FETCH_HI;
        end else if (fetch_done) begin
          load_lo = 1'b1;
          pc_inc  = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (branch) begin
          pc_load = 1'b1;
          state_d = FETCH_HI;
        end else if (decode_accept && decode_valid) begin
          state_d = (ir_q[OPCODE_MSB:OPCODE_LSB] == OP_HALT) ? HALTED : FETCH_HI;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH_HI;
    endcase
  end

  // Handshake flags are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_HI;
      mem_read     <= 1'b0;
      decode_valid <= 1'b0;
      halt         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read     <= (state_d == FETCH_HI) || (state_d == FETCH_LO);
      decode_valid <= (state_d == VALID);
      halt         <= (state_d == HALTED);
    end
  end

  // Instruction register; cs is decoded inline as the high byte lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
      cs   <= 1'b0;
    end else begin
      if (load_hi) begin
        ir_q[15:8] <= mem_data;
        cs         <= (mem_data[7:4] == OP_ADDI) || (mem_data[7:4] == OP_SUBI) ||
                      (mem_data[7:4] == OP_LDI)  || (mem_data[7:4] == OP_BRO);
      end
      if (load_lo) begin
        ir_q[7:0] <= mem_data;
      end
    end
  end

  assign opcode         = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rd             = ir_q[RD_MSB:RD_LSB];
  assign rs             = ir_q[RS_MSB:RS_LSB];
  assign immediate_data = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder with a byte-array memory model.
module tb_instruction_decoder;
  import instruction_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_addr;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        branch;
  logic [7:0]  branch_target;
  logic        decode_valid;
  logic        decode_accept;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [5:0]  immediate_data;
  logic        cs;
  logic        halt;

  logic [7:0]  mem [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  instruction_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .branch         (branch),
    .branch_target  (branch_target),
    .decode_valid   (decode_valid),
    .decode_accept  (decode_accept),
    .opcode         (opcode),
    .rd             (rd),
    .rs             (rs),
    .immediate_data (immediate_data),
    .cs             (cs),
    .halt           (halt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] fields();
    return {opcode, rd, rs, immediate_data};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h8A; mem[8'h01] = 8'hFE;
    mem[8'h02] = 8'h12; mem[8'h03] = 8'h34;
    mem[8'h50] = {OP_ANDI, 4'h1}; mem[8'h51] = 8'h23;
    mem[8'h40] = {OP_ORI, 4'h0};  mem[8'h41] = 8'h00;
    mem[8'hFE] = {OP_HALT, 4'h0}; mem[8'hFF] = 8'h00;

    rst_n = 1'b0; branch = 1'b0; branch_target = 8'h00;
    mem_ready = 1'b0; decode_accept = 1'b0;
    #12;
    check("rst_mem_read", 16'(mem_read), 16'h0);
    check("rst_decode_valid", 16'(decode_valid), 16'h0);
    check("rst_halt", 16'(halt), 16'h0);
    check("rst_fields", fields(), 16'h0000);
    check("rst_cs", 16'(cs), 16'h0);
    check("rst_mem_addr", 16'(mem_addr), 16'h00);

    // Sequential fetch with memory always ready
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("seq_c1_mem_read", 16'(mem_read), 16'h1);
    check("seq_c1_addr", 16'(mem_addr), 16'h00);
    @(negedge clk);
    check("seq_c2_addr", 16'(mem_addr), 16'h01);
    check("seq_c2_valid", 16'(decode_valid), 16'h0);
    @(negedge clk);
    check("seq_c3_valid", 16'(decode_valid), 16'h1);
    check("seq_opcode", 16'(opcode), 16'h8);
    check("seq_rd", 16'(rd), 16'h5);
    check("seq_rs", 16'(rs), 16'h3);
    check("seq_imm", 16'(immediate_data), 16'h3E);
    check("seq_cs", 16'(cs), 16'h1);
    check("seq_mem_read", 16'(mem_read), 16'h0);

    // Backpressure: ready stays high but must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 16'(decode_valid), 16'h1);
      check("bp_mem_read", 16'(mem_read), 16'h0);
      check("bp_fields", fields(), 16'h8AFE);
      check("bp_addr", 16'(mem_addr), 16'h02);
    end
    decode_accept = 1'b1; mem_ready = 1'b0;
    @(negedge clk); decode_accept = 1'b0;
    check("acc_mem_read", 16'(mem_read), 16'h1);
    check("acc_addr", 16'(mem_addr), 16'h02);
    check("acc_valid", 16'(decode_valid), 16'h0);

    // Wait states during the low byte
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ws_addr", 16'(mem_addr), 16'h03);
      check("ws_mem_read", 16'(mem_read), 16'h1);
      check("ws_valid", 16'(decode_valid), 16'h0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("ws_valid_done", 16'(decode_valid), 16'h1);
    check("ws_fields", fields(), 16'h1234);
    check("ws_cs", 16'(cs), 16'h0);
    check("ws_addr_after", 16'(mem_addr), 16'h04);

    // Redirect out of VALID beats a simultaneous accept
    branch = 1'b1; branch_target = 8'h50; decode_accept = 1'b1;
    @(negedge clk); branch = 1'b0; decode_accept = 1'b0;
    check("brv_valid", 16'(decode_valid), 16'h0);
    check("brv_mem_read", 16'(mem_read), 16'h1);
    check("brv_addr", 16'(mem_addr), 16'h50);

    // Branch collides with MemReady in FETCH_LO
    @(negedge clk);
    check("col_addr_lo", 16'(mem_addr), 16'h51);
    branch = 1'b1; branch_target = 8'h40;
    @(negedge clk); branch = 1'b0;
    check("col_addr", 16'(mem_addr), 16'h40);
    check("col_mem_read", 16'(mem_read), 16'h1);
    check("col_valid", 16'(decode_valid), 16'h0);
    check("col_fields", fields(), 16'hC134);
    check("col_cs_andi", 16'(cs), 16'h0);
    @(negedge clk);
    check("col_refetch_addr", 16'(mem_addr), 16'h41);
    @(negedge clk);
    check("ori_valid", 16'(decode_valid), 16'h1);
    check("ori_fields", fields(), 16'hD000);
    check("ori_cs", 16'(cs), 16'h0);

    // Wrap through 0xFF and halt
    decode_accept = 1'b1;
    @(negedge clk); decode_accept = 1'b0; mem_ready = 1'b0;
    check("pre_halt_addr", 16'(mem_addr), 16'h42);
    branch = 1'b1; branch_target = 8'hFE;
    @(negedge clk); branch = 1'b0;
    check("wrap_start", 16'(mem_addr), 16'hFE);
    mem_ready = 1'b1;
    @(negedge clk);
    check("wrap_ff", 16'(mem_addr), 16'hFF);
    @(negedge clk);
    check("wrap_addr", 16'(mem_addr), 16'h00);
    check("halt_instr", fields(), 16'hF000);
    check("halt_instr_valid", 16'(decode_valid), 16'h1);
    decode_accept = 1'b1;
    @(negedge clk);
    check("halt_set", 16'(halt), 16'h1);
    check("halt_mem_read", 16'(mem_read), 16'h0);
    check("halt_valid", 16'(decode_valid), 16'h0);
    branch = 1'b1; branch_target = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_hold", 16'(halt), 16'h1);
      check("halt_hold_read", 16'(mem_read), 16'h0);
      check("halt_hold_addr", 16'(mem_addr), 16'h00);
    end
    branch = 1'b0; decode_accept = 1'b0;

    // Reset leaves HALTED
    #2 rst_n = 1'b0;
    #1 check("rst2_halt", 16'(halt), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst2_mem_read", 16'(mem_read), 16'h1);
    check("rst2_addr", 16'(mem_addr), 16'h00);
    @(negedge clk);
    check("mid_lo_addr", 16'(mem_addr), 16'h01);
    check("mid_lo_cs", 16'(cs), 16'h1);

    // Async reset between edges during FETCH_LO
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_read", 16'(mem_read), 16'h0);
    check("arst_addr", 16'(mem_addr), 16'h00);
    check("arst_fields", fields(), 16'h0000);
    check("arst_cs", 16'(cs), 16'h0);
    check("arst_valid", 16'(decode_valid), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("restart_read", 16'(mem_read), 16'h1);
    check("restart_addr", 16'(mem_addr), 16'h00);
    @(negedge clk);
    @(negedge clk);
    check("restart_valid", 16'(decode_valid), 16'h1);
    check("restart_fields", fields(), 16'h8AFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
